// File: rtl/axi_ram_arbiter.sv
// Round-robin arbiter sharing one axi_ram slave between N_MASTERS AXI masters.
// Write (AW/W/B) and read (AR/R) paths are arbitrated independently, each with
// one transaction in flight; routing follows the locked grant, never the ID.

package axi_ram_arbiter_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;

    typedef struct packed {
        logic [ID_W-1:0]   awid;
        logic [ADDR_W-1:0] awaddr;
        logic [LEN_W-1:0]  awlen;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wlast;
        logic              wvalid;
        logic              bready;
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [LEN_W-1:0]  arlen;
        logic              arvalid;
        logic              rready;
    } axi_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        logic [RESP_W-1:0] bresp;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [RESP_W-1:0] rresp;
        logic              rlast;
        logic              rvalid;
    } axi_miso_t;

endpackage

module axi_ram_arbiter
    import axi_ram_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  axi_mosi_t            in_mosi_i [N_MASTERS],
    output axi_miso_t            in_miso_o [N_MASTERS],
    output axi_mosi_t            out_mosi_o,
    input  axi_miso_t            out_miso_i,
    output logic [N_MASTERS-1:0] wr_grant_o,
    output logic [N_MASTERS-1:0] rd_grant_o
);

    localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;

    wr_state_t            wr_state, wr_state_nxt;
    rd_state_t            rd_state, rd_state_nxt;
    logic [IDX_W-1:0]     wr_idx, wr_idx_nxt, wr_ptr, wr_ptr_nxt, wr_pick;
    logic [IDX_W-1:0]     rd_idx, rd_idx_nxt, rd_ptr, rd_ptr_nxt, rd_pick;
    logic [N_MASTERS-1:0] wr_grant_nxt, rd_grant_nxt;
    logic [N_MASTERS-1:0] wr_req, rd_req;

    // First requester at or after ptr, wrapping around the master list.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0]     ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        int unsigned      j;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            j = 32'(ptr) + i;
            if (j >= N_MASTERS) j = j - N_MASTERS;
            cand = IDX_W'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return pick;
    endfunction

    // Index following idx, modulo N_MASTERS.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (32'(idx) == N_MASTERS - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    // Request vectors gathered from the master-side VALIDs.
    always_comb begin
        wr_req = '0;
        rd_req = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            wr_req[i] = in_mosi_i[i].awvalid;
            rd_req[i] = in_mosi_i[i].arvalid;
        end
    end

    // Write path state, locked index, pointer and grant registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state   <= WR_IDLE;
            wr_idx     <= '0;
            wr_ptr     <= '0;
            wr_grant_o <= '0;
        end else begin
            wr_state   <= wr_state_nxt;
            wr_idx     <= wr_idx_nxt;
            wr_ptr     <= wr_ptr_nxt;
            wr_grant_o <= wr_grant_nxt;
        end
    end

    // Write FSM: arbitrate in IDLE, then walk AW -> W -> B on handshakes.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_idx_nxt   = wr_idx;
        wr_ptr_nxt   = wr_ptr;
        wr_grant_nxt = wr_grant_o;
        wr_pick      = rr_pick(wr_req, wr_ptr);
        case (wr_state)
            WR_IDLE: if (|wr_req) begin
                wr_state_nxt = WR_AW;
                wr_idx_nxt   = wr_pick;
                wr_grant_nxt = N_MASTERS'(1) << wr_pick;
            end
            WR_AW: if (in_mosi_i[wr_idx].awvalid && out_miso_i.awready) wr_state_nxt = WR_W;
            WR_W: if (in_mosi_i[wr_idx].wvalid && out_miso_i.wready && in_mosi_i[wr_idx].wlast)
                wr_state_nxt = WR_B;
            WR_B: if (out_miso_i.bvalid && in_mosi_i[wr_idx].bready) begin
                wr_state_nxt = WR_IDLE;
                wr_ptr_nxt   = rr_next(wr_idx);
                wr_grant_nxt = '0;
            end
            default: begin
                wr_state_nxt = WR_IDLE;
                wr_grant_nxt = '0;
            end
        endcase
    end

    // Read path state, locked index, pointer and grant registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_state   <= RD_IDLE;
            rd_idx     <= '0;
            rd_ptr     <= '0;
            rd_grant_o <= '0;
        end else begin
            rd_state   <= rd_state_nxt;
            rd_idx     <= rd_idx_nxt;
            rd_ptr     <= rd_ptr_nxt;
            rd_grant_o <= rd_grant_nxt;
        end
    end

    // Read FSM: arbitrate in IDLE, then AR -> R until the RLAST handshake.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_idx_nxt   = rd_idx;
        rd_ptr_nxt   = rd_ptr;
        rd_grant_nxt = rd_grant_o;
        rd_pick      = rr_pick(rd_req, rd_ptr);
        case (rd_state)
            RD_IDLE: if (|rd_req) begin
                rd_state_nxt = RD_AR;
                rd_idx_nxt   = rd_pick;
                rd_grant_nxt = N_MASTERS'(1) << rd_pick;
            end
            RD_AR: if (in_mosi_i[rd_idx].arvalid && out_miso_i.arready) rd_state_nxt = RD_R;
            RD_R: if (out_miso_i.rvalid && in_mosi_i[rd_idx].rready && out_miso_i.rlast) begin
                rd_state_nxt = RD_IDLE;
                rd_ptr_nxt   = rr_next(rd_idx);
                rd_grant_nxt = '0;
            end
            default: begin
                rd_state_nxt = RD_IDLE;
                rd_grant_nxt = '0;
            end
        endcase
    end

    // Zero-latency forwarding of the active channel between the granted master and the slave.
    always_comb begin
        out_mosi_o = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) in_miso_o[i] = '0;
        case (wr_state)
            WR_AW: begin
                out_mosi_o.awid            = in_mosi_i[wr_idx].awid;
                out_mosi_o.awaddr          = in_mosi_i[wr_idx].awaddr;
                out_mosi_o.awlen           = in_mosi_i[wr_idx].awlen;
                out_mosi_o.awvalid         = in_mosi_i[wr_idx].awvalid;
                in_miso_o[wr_idx].awready  = out_miso_i.awready;
            end
            WR_W: begin
                out_mosi_o.wdata           = in_mosi_i[wr_idx].wdata;
                out_mosi_o.wstrb           = in_mosi_i[wr_idx].wstrb;
                out_mosi_o.wlast           = in_mosi_i[wr_idx].wlast;
                out_mosi_o.wvalid          = in_mosi_i[wr_idx].wvalid;
                in_miso_o[wr_idx].wready   = out_miso_i.wready;
            end
            WR_B: begin
                out_mosi_o.bready          = in_mosi_i[wr_idx].bready;
                in_miso_o[wr_idx].bid      = out_miso_i.bid;
                in_miso_o[wr_idx].bresp    = out_miso_i.bresp;
                in_miso_o[wr_idx].bvalid   = out_miso_i.bvalid;
            end
            default: ;
        endcase
        case (rd_state)
            RD_AR: begin
                out_mosi_o.arid            = in_mosi_i[rd_idx].arid;
                out_mosi_o.araddr          = in_mosi_i[rd_idx].araddr;
                out_mosi_o.arlen           = in_mosi_i[rd_idx].arlen;
                out_mosi_o.arvalid         = in_mosi_i[rd_idx].arvalid;
                in_miso_o[rd_idx].arready  = out_miso_i.arready;
            end
            RD_R: begin
                out_mosi_o.rready          = in_mosi_i[rd_idx].rready;
                in_miso_o[rd_idx].rid      = out_miso_i.rid;
                in_miso_o[rd_idx].rdata    = out_miso_i.rdata;
                in_miso_o[rd_idx].rresp    = out_miso_i.rresp;
                in_miso_o[rd_idx].rlast    = out_miso_i.rlast;
                in_miso_o[rd_idx].rvalid   = out_miso_i.rvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Directed bench for axi_ram_arbiter with two masters and a small always-ready
// slave model that logs W beats and answers reads with address-tagged data.

module tb_axi_ram_arbiter;
    import axi_ram_arbiter_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    axi_mosi_t m_mosi [2];
    axi_miso_t m_miso [2];
    axi_mosi_t s_mosi;
    axi_miso_t s_miso;
    logic [1:0] wr_grant, rd_grant;

    int errors = 0;
    int checks = 0;

    axi_mosi_t zero_mosi;
    axi_miso_t zero_miso;

    always #5 clk = ~clk;

    axi_ram_arbiter #(.N_MASTERS(2)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_mosi_i  (m_mosi),
        .in_miso_o  (m_miso),
        .out_mosi_o (s_mosi),
        .out_miso_i (s_miso),
        .wr_grant_o (wr_grant),
        .rd_grant_o (rd_grant)
    );

    // Slave model state.
    logic        s_bvalid, s_rbusy;
    logic [3:0]  s_bid, s_awid, s_rid;
    logic [15:0] s_raddr;
    logic [7:0]  s_rlen, s_rcnt;

    always_comb begin
        s_miso         = '0;
        s_miso.awready = 1'b1;
        s_miso.wready  = 1'b1;
        s_miso.bvalid  = s_bvalid;
        s_miso.bid     = s_bid;
        s_miso.arready = !s_rbusy;
        s_miso.rvalid  = s_rbusy;
        s_miso.rid     = s_rid;
        s_miso.rdata   = {16'hD000, s_raddr + 16'(s_rcnt)};
        s_miso.rlast   = s_rbusy && (s_rcnt == s_rlen);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bvalid <= 1'b0; s_bid <= '0; s_awid <= '0;
            s_rbusy <= 1'b0; s_rid <= '0; s_raddr <= '0; s_rlen <= '0; s_rcnt <= '0;
        end else begin
            if (s_mosi.awvalid) s_awid <= s_mosi.awid;
            if (s_mosi.wvalid && s_mosi.wlast) begin
                s_bvalid <= 1'b1;
                s_bid    <= s_awid;
            end else if (s_bvalid && s_mosi.bready) begin
                s_bvalid <= 1'b0;
            end
            if (!s_rbusy && s_mosi.arvalid) begin
                s_rbusy <= 1'b1; s_rid <= s_mosi.arid; s_raddr <= s_mosi.araddr;
                s_rlen  <= s_mosi.arlen; s_rcnt <= '0;
            end else if (s_rbusy && s_mosi.rready) begin
                if (s_rcnt == s_rlen) s_rbusy <= 1'b0;
                else                  s_rcnt  <= s_rcnt + 8'd1;
            end
        end
    end

    // W beats as seen by the slave; survives resets so aborted bursts stay visible.
    logic [32:0] wlog [64];
    logic [5:0]  wcnt = '0;
    always @(posedge clk) begin
        if (rst_n && s_mosi.wvalid && s_miso.wready) begin
            wlog[wcnt] <= {s_mosi.wlast, s_mosi.wdata};
            wcnt       <= wcnt + 6'd1;
        end
    end

    task automatic check(input string tag, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_masters();
        for (int i = 0; i < 2; i++) begin
            m_mosi[i]       = '0;
            m_mosi[i].wstrb = 4'hF;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        int         gi;
        int         rbeats;
        logic [5:0] base;

        zero_mosi = '0;
        zero_miso = '0;
        clear_masters();

        // Reset held with every master VALID/READY high.
        for (int i = 0; i < 2; i++) begin
            m_mosi[i].awvalid = 1'b1; m_mosi[i].awaddr = 16'h1234; m_mosi[i].awid = 4'hA;
            m_mosi[i].wvalid  = 1'b1; m_mosi[i].wlast  = 1'b1;     m_mosi[i].wdata = 32'hDEAD;
            m_mosi[i].bready  = 1'b1; m_mosi[i].arvalid = 1'b1;    m_mosi[i].araddr = 16'h5678;
            m_mosi[i].rready  = 1'b1;
        end
        tick(); tick(); settle();
        check("rst_out_mosi", s_mosi === zero_mosi);
        check("rst_m0_miso", m_miso[0] === zero_miso);
        check("rst_m1_miso", m_miso[1] === zero_miso);
        check("rst_wr_grant", wr_grant === 2'b00);
        check("rst_rd_grant", rd_grant === 2'b00);
        rst_n = 1'b1;
        tick(); settle();
        check("rst_first_wr_grant", wr_grant === 2'b01);
        check("rst_first_rd_grant", rd_grant === 2'b01);
        rst_n = 1'b0;
        clear_masters();
        tick();
        rst_n = 1'b1;
        tick();

        // Contention: both masters keep AWVALID high, len=0, four transactions.
        for (int i = 0; i < 2; i++) begin
            m_mosi[i].awvalid = 1'b1; m_mosi[i].awid = 4'(i + 1); m_mosi[i].awaddr = 16'(16'h100 * (i + 1));
            m_mosi[i].awlen   = 8'd0; m_mosi[i].wvalid = 1'b1;    m_mosi[i].wlast = 1'b1;
            m_mosi[i].wdata   = 32'(32'h11 * (i + 1)); m_mosi[i].bready = 1'b1;
        end
        for (int t = 0; t < 4; t++) begin
            gi = t % 2;
            g  = (gi == 1) ? 2'b10 : 2'b01;
            tick(); settle();
            check("cont_wr_grant", wr_grant === g);
            check("cont_awready_owner", m_miso[gi].awready === 1'b1);
            check("cont_awready_other", m_miso[1 - gi].awready === 1'b0);
            tick(); tick(); settle();
            check("cont_bvalid_owner", m_miso[gi].bvalid === 1'b1);
            check("cont_bid_owner", m_miso[gi].bid === 4'(gi + 1));
            check("cont_bvalid_other", m_miso[1 - gi].bvalid === 1'b0);
            tick(); settle();
            check("cont_idle_grant", wr_grant === 2'b00);
        end
        clear_masters();
        tick();

        // Single write: M0 addr 0x0010 len=3, W beat presented before the grant.
        base = wcnt;
        m_mosi[0].awvalid = 1'b1; m_mosi[0].awid = 4'd5; m_mosi[0].awaddr = 16'h0010; m_mosi[0].awlen = 8'd3;
        m_mosi[0].wvalid  = 1'b1; m_mosi[0].wdata = 32'hA0; m_mosi[0].bready = 1'b1;
        settle();
        check("sw_wready_idle", m_miso[0].wready === 1'b0);
        check("sw_grant_idle", wr_grant === 2'b00);
        tick(); settle();
        check("sw_wr_grant", wr_grant === 2'b01);
        check("sw_fwd_awaddr", s_mosi.awaddr === 16'h0010);
        check("sw_awready", m_miso[0].awready === 1'b1);
        check("sw_wready_aw", m_miso[0].wready === 1'b0);
        tick();
        m_mosi[0].awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_mosi[0].wdata = 32'hA0 + 32'(b);
            m_mosi[0].wlast = (b == 3);
            tick();
        end
        m_mosi[0].wvalid = 1'b0; m_mosi[0].wlast = 1'b0;
        settle();
        check("sw_bvalid", m_miso[0].bvalid === 1'b1);
        check("sw_bid", m_miso[0].bid === 4'd5);
        check("sw_beats", 6'(wcnt - base) === 6'd4);
        check("sw_beat3", wlog[base + 6'd3] === {1'b1, 32'hA3});
        check("sw_beat2", wlog[base + 6'd2] === {1'b0, 32'hA2});
        tick(); settle();
        check("sw_idle_grant", wr_grant === 2'b00);
        clear_masters();

        // Concurrent: M0 writes 0x0020 len=7 while M1 reads 0x0040 len=7.
        m_mosi[0].awvalid = 1'b1; m_mosi[0].awid = 4'd3; m_mosi[0].awaddr = 16'h0020; m_mosi[0].awlen = 8'd7;
        m_mosi[0].wvalid  = 1'b1; m_mosi[0].wdata = 32'hB0; m_mosi[0].bready = 1'b1;
        m_mosi[1].arvalid = 1'b1; m_mosi[1].arid = 4'd6; m_mosi[1].araddr = 16'h0040; m_mosi[1].arlen = 8'd7;
        m_mosi[1].rready  = 1'b1;
        tick(); settle();
        check("cc_wr_grant", wr_grant === 2'b01);
        check("cc_rd_grant", rd_grant === 2'b10);
        tick();
        m_mosi[0].awvalid = 1'b0; m_mosi[1].arvalid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            m_mosi[0].wdata = 32'hB0 + 32'(b);
            m_mosi[0].wlast = (b == 7);
            settle();
            check("cc_both_busy", {wr_grant, rd_grant} === 4'b0110);
            check("cc_rdata_m1", m_miso[1].rdata === 32'hD000_0040 + 32'(b));
            check("cc_rlast_m1", m_miso[1].rlast === (b == 7));
            check("cc_rvalid_m0", m_miso[0].rvalid === 1'b0);
            tick();
        end
        m_mosi[0].wvalid = 1'b0; m_mosi[0].wlast = 1'b0;
        settle();
        check("cc_rd_idle", rd_grant === 2'b00);
        check("cc_bvalid_m0", m_miso[0].bvalid === 1'b1);
        check("cc_bid_m0", m_miso[0].bid === 4'd3);
        check("cc_bvalid_m1", m_miso[1].bvalid === 1'b0);
        tick(); settle();
        check("cc_wr_idle", wr_grant === 2'b00);
        clear_masters();

        // Backpressure: M1 read len=2 with RREADY pattern 1,0,0,1,0,0,1.
        m_mosi[1].arvalid = 1'b1; m_mosi[1].arid = 4'd7; m_mosi[1].araddr = 16'h0080; m_mosi[1].arlen = 8'd2;
        tick(); settle();
        check("bp_rd_grant", rd_grant === 2'b10);
        tick();
        m_mosi[1].arvalid = 1'b0;
        rbeats = 0;
        for (int c = 0; c < 7; c++) begin
            m_mosi[1].rready = (c % 3 == 0);
            settle();
            check("bp_rvalid", m_miso[1].rvalid === 1'b1);
            check("bp_rdata", m_miso[1].rdata === 32'hD000_0080 + 32'((c + 2) / 3));
            check("bp_rlast", m_miso[1].rlast === (c >= 4));
            check("bp_grant_hold", rd_grant === 2'b10);
            if (m_miso[1].rvalid && m_mosi[1].rready) rbeats++;
            tick();
        end
        settle();
        check("bp_beats", rbeats === 3);
        check("bp_rd_idle", rd_grant === 2'b00);
        check("bp_rvalid_idle", m_miso[1].rvalid === 1'b0);
        clear_masters();

        // Reset after W beat 2 of a len=3 burst, then a fresh M1 write.
        m_mosi[0].awvalid = 1'b1; m_mosi[0].awid = 4'd4; m_mosi[0].awaddr = 16'h0030; m_mosi[0].awlen = 8'd3;
        m_mosi[0].wvalid  = 1'b1; m_mosi[0].wdata = 32'hC0; m_mosi[0].bready = 1'b1;
        tick(); settle();
        check("rb_wr_grant", wr_grant === 2'b01);
        tick();
        m_mosi[0].awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_mosi[0].wdata = 32'hC0 + 32'(b);
            tick();
        end
        rst_n = 1'b0;
        settle();
        check("rb_grant_zero", wr_grant === 2'b00);
        check("rb_out_mosi", s_mosi === zero_mosi);
        check("rb_m0_miso", m_miso[0] === zero_miso);
        clear_masters();
        tick(); settle();
        check("rb_no_bvalid", m_miso[0].bvalid === 1'b0);
        rst_n = 1'b1;
        tick();
        base = wcnt;
        m_mosi[1].awvalid = 1'b1; m_mosi[1].awid = 4'd9; m_mosi[1].awaddr = 16'h0050; m_mosi[1].awlen = 8'd0;
        m_mosi[1].wvalid  = 1'b1; m_mosi[1].wdata = 32'h55; m_mosi[1].wlast = 1'b1; m_mosi[1].bready = 1'b1;
        tick(); settle();
        check("rb_new_grant", wr_grant === 2'b10);
        tick();
        m_mosi[1].awvalid = 1'b0;
        tick();
        m_mosi[1].wvalid = 1'b0;
        settle();
        check("rb_new_bvalid", m_miso[1].bvalid === 1'b1);
        check("rb_new_bid", m_miso[1].bid === 4'd9);
        check("rb_new_beat", wlog[base] === {1'b1, 32'h55});
        check("rb_m0_quiet", m_miso[0].bvalid === 1'b0);
        tick(); settle();
        check("rb_new_idle", wr_grant === 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
